// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for a shared 32-way one-hot select path. The grant is held
// until the owner releases, withdraws its request, or reaches the MAX_HOLD limit.
module rr_arbiter_32 #(
  parameter int N_REQ    = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // An unlimited hold (MAX_HOLD = 0) still needs a one-bit counter to keep widths legal.
  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W-1:0] gnt_idx_nx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic             hold_at_max;
  logic             timeout_nx;

  // Priority search starting at ptr; the 5-bit sum wraps 31 -> 0 on its own.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand       = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign hold_at_max = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    gnt_idx_nx  = gnt_idx;
    hold_cnt_nx = hold_cnt;
    timeout_nx  = 1'b0;
    case (state)
      IDLE: begin
        hold_cnt_nx = '0;
        if (pick_found) begin
          gnt_idx_nx  = pick_idx;
          hold_cnt_nx = CNT_W'(1);
          state_nx    = GRANT;
        end
      end
      GRANT: begin
        if (done || !req[gnt_idx] || hold_at_max) begin
          state_nx    = GAP;
          ptr_nx      = gnt_idx + IDX_W'(1);
          hold_cnt_nx = '0;
          // A release by done or withdrawal takes precedence over the hold limit.
          timeout_nx  = !done && req[gnt_idx] && hold_at_max;
        end else if (MAX_HOLD != 0) begin
          hold_cnt_nx = hold_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        hold_cnt_nx = '0;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      gnt_idx  <= gnt_idx_nx;
      hold_cnt <= hold_cnt_nx;
      timeout  <= timeout_nx;
    end
  end

  // Outputs derive only from registers; the decode is fed by gnt_idx alone, so gnt is one-hot or zero.
  assign gnt_valid = (state == GRANT);
  assign gnt       = gnt_valid ? (N_REQ'(1) << gnt_idx) : '0;

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Self-checking bench for rr_arbiter_32: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_rr_arbiter_32;

  localparam int MAXH = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the path, for how long, and where the search starts next.
  int m_owner;
  int m_last;
  int m_age;
  int m_next;
  bit m_gap;
  bit m_timeout;

  rr_arbiter_32 #(.N_REQ(32), .IDX_W(5), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 0;
    m_age     = 0;
    m_next    = 0;
    m_gap     = 1'b0;
    m_timeout = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] r, input logic d);
    m_timeout = 1'b0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || m_age == MAXH) begin
        m_timeout = !d && r[m_owner] && (m_age == MAXH);
        m_next    = (m_owner + 1) % 32;
        m_owner   = -1;
        m_gap     = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        int j;
        j = (m_next + i) % 32;
        if (m_owner < 0 && r[j]) begin
          m_owner = j;
          m_last  = j;
          m_age   = 1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [31:0] e_gnt;
    e_gnt = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
    check("model_gnt",       gnt,                e_gnt);
    check("model_gnt_idx",   {27'd0, gnt_idx},   32'(m_last));
    check("model_gnt_valid", {31'd0, gnt_valid}, {31'd0, (m_owner >= 0)});
    check("model_timeout",   {31'd0, timeout},   {31'd0, m_timeout});
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare just after.
  task automatic step(input logic [31:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_gnt",       gnt,                32'h0);
    check("rst_gnt_idx",   {27'd0, gnt_idx},   32'h0);
    check("rst_gnt_valid", {31'd0, gnt_valid}, 32'h0);
    check("rst_timeout",   {31'd0, timeout},   32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic        d;
    rst_n = 1'b1;
    req   = '0;
    done  = 1'b0;
    #2;

    // Reset then a single request.
    do_reset();
    step(32'h0000_0010, 1'b0);
    check("single_gnt",   gnt,                32'h0000_0010);
    check("single_idx",   {27'd0, gnt_idx},   32'd4);
    check("single_valid", {31'd0, gnt_valid}, 32'd1);
    step(32'h0000_0010, 1'b1);
    check("single_release", gnt, 32'h0);
    step(32'h0, 1'b0);

    // Fairness: every requester in turn, two dead cycles between grants, wrapping 31 -> 0.
    do_reset();
    step(32'hFFFF_FFFF, 1'b0);
    check("rr_first_idx", {27'd0, gnt_idx}, 32'd0);
    for (int i = 1; i <= 32; i++) begin
      step(32'hFFFF_FFFF, 1'b1);
      check("rr_gap", gnt, 32'h0);
      step(32'hFFFF_FFFF, 1'b0);
      check("rr_idle", gnt, 32'h0);
      step(32'hFFFF_FFFF, 1'b0);
      check("rr_idx", {27'd0, gnt_idx}, 32'(i % 32));
    end

    // Wrap-around: after owner 31 releases, index 0 is next.
    do_reset();
    step(32'h8000_0000, 1'b0);
    check("wrap_owner31", {27'd0, gnt_idx}, 32'd31);
    step(32'h8000_0001, 1'b1);
    step(32'h8000_0001, 1'b0);
    step(32'h8000_0001, 1'b0);
    check("wrap_idx0", gnt, 32'h0000_0001);

    // Timeout: exactly MAXH cycles of ownership, then a one-cycle pulse on GAP.
    do_reset();
    for (int c = 1; c <= MAXH; c++) begin
      step(32'h0000_0100, 1'b0);
      check("hold_gnt", gnt, 32'h0000_0100);
    end
    step(32'h0000_0100, 1'b0);
    check("to_pulse", {31'd0, timeout}, 32'd1);
    check("to_gnt0",  gnt,              32'h0);
    step(32'h0000_0100, 1'b0);
    check("to_idle_gnt",  gnt,              32'h0);
    check("to_idle_tout", {31'd0, timeout}, 32'd0);
    step(32'h0000_0100, 1'b0);
    check("to_regrant", gnt, 32'h0000_0100);

    // Owner withdrawal.
    do_reset();
    step(32'h0000_0008, 1'b0);
    step(32'h0000_0008, 1'b0);
    step(32'h0000_0000, 1'b0);
    check("wd_gnt",  gnt,              32'h0);
    check("wd_tout", {31'd0, timeout}, 32'd0);

    // done on the cycle the hold limit is reached: no timeout.
    do_reset();
    for (int c = 1; c <= MAXH; c++) step(32'h0000_0100, 1'b0);
    step(32'h0000_0100, 1'b1);
    check("coll_gnt",  gnt,              32'h0);
    check("coll_tout", {31'd0, timeout}, 32'd0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    step(32'h0010_0000, 1'b0);
    check("mid_idx20", {27'd0, gnt_idx}, 32'd20);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_gnt", gnt,              32'h0);
    check("async_idx", {27'd0, gnt_idx}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(32'h0010_0001, 1'b0);
    check("post_rst_idx0", gnt, 32'h0000_0001);

    // Randomized traffic against the model.
    do_reset();
    r = '0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: r = 32'h0;
          1: r = $urandom;
          2: r = 32'h1 << $urandom_range(0, 31);
          3: r = 32'hFFFF_FFFF;
          default: r = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        endcase
      end
      d = ($urandom_range(0, 7) == 0);
      step(r, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
